// File: rtl/tmds_decoder_if.sv
// Signal bundle between a TMDS word source and one colour-channel decoder.
// master drives the raw deserialized word; slave returns the decoded symbol stream.
interface tmds_decoder_if;
  logic [9:0] tmds_in;
  logic [7:0] VD;
  logic [1:0] CD;
  logic       VDE;
  logic       locked;
  logic [3:0] align_offset;
  logic       disp_err;

  modport master (
    output tmds_in,
    input  VD, CD, VDE, locked, align_offset, disp_err
  );

  modport slave (
    input  tmds_in,
    output VD, CD, VDE, locked, align_offset, disp_err
  );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS receive decoder for one channel: word alignment from control-token runs,
// 8b/10b symbol decode and running-disparity supervision with loss-of-lock.
module tmds_decoder #(
  parameter int CTRL_RUN      = 8,
  parameter int SEARCH_CYCLES = 2048,
  parameter int ERR_LIMIT     = 4,
  parameter int DISP_LIMIT    = 16
) (
  input logic           clk,
  input logic           rst,
  tmds_decoder_if.slave bus
);

  localparam int RUN_W = $clog2(CTRL_RUN + 1);
  localparam int CYC_W = $clog2(SEARCH_CYCLES + 1);
  localparam int ERR_W = $clog2(ERR_LIMIT + 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_reg;
  logic [9:0]         w1_reg;
  logic [9:0]         w0_reg;
  logic [9:0]         sym_reg;
  logic               skip_reg;
  logic [3:0]         offset_reg;
  logic [RUN_W-1:0]   run_reg;
  logic [CYC_W-1:0]   cyc_reg;
  logic [ERR_W-1:0]   err_reg;
  logic signed [5:0]  acc_reg;
  logic [7:0]         vd_reg;
  logic [1:0]         cd_reg;
  logic               vde_reg;
  logic               locked_reg;
  logic               disp_err_reg;

  // Bit 19 of the 20-bit window is never reachable with offsets 0..9.
  logic [18:0] window;
  logic [9:0]  cand [10];
  logic [9:0]  sym_sel;

  assign window = {w1_reg[8:0], w0_reg};

  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_cand
      assign cand[gi] = window[gi+9:gi];
    end
  endgenerate

  always_comb begin
    sym_sel = cand[0];
    for (int i = 1; i < 10; i++) begin
      if (offset_reg == 4'(i)) begin
        sym_sel = cand[i];
      end
    end
  end

  logic       is_ctrl;
  logic [1:0] ctrl_val;

  always_comb begin
    is_ctrl  = 1'b1;
    ctrl_val = 2'b00;
    case (sym_reg)
      10'b1101010100: ctrl_val = 2'b00;
      10'b0010101011: ctrl_val = 2'b01;
      10'b0101010100: ctrl_val = 2'b10;
      10'b1010101011: ctrl_val = 2'b11;
      default:        is_ctrl  = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  logic [7:0] d_word;
  logic [7:0] vd_dec;

  assign d_word    = sym_reg[9] ? ~sym_reg[7:0] : sym_reg[7:0];
  assign vd_dec[0] = d_word[0];

  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_vd
      assign vd_dec[gi] = sym_reg[8] ? (d_word[gi] ^ d_word[gi-1])
                                     : ~(d_word[gi] ^ d_word[gi-1]);
    end
  endgenerate

  logic [3:0]        pop;
  logic signed [6:0] acc_sum;
  logic signed [5:0] acc_sat;
  logic [6:0]        acc_mag;
  logic              over_limit;

  always_comb begin
    pop = 4'd0;
    for (int i = 0; i < 10; i++) begin
      pop = pop + {3'b000, sym_reg[i]};
    end
  end

  always_comb begin
    acc_sum = $signed({acc_reg[5], acc_reg}) + $signed({3'b000, pop}) - 7'sd5;
    if (acc_sum > 7'sd31) begin
      acc_sat = 6'b01_1111;
    end else if (acc_sum < -7'sd32) begin
      acc_sat = 6'b10_0000;
    end else begin
      acc_sat = acc_sum[5:0];
    end
    acc_mag    = acc_sat[5] ? (7'd0 - {acc_sat[5], acc_sat}) : {1'b0, acc_sat};
    over_limit = (acc_mag > 7'(DISP_LIMIT));
  end

  logic       err_event;
  logic       lock_now;
  logic       drop_now;
  logic       locked_next;
  logic [3:0] offset_inc;

  // Control tokens never count as disparity errors, so they also clear err_cnt first.
  assign err_event   = (state_reg == LOCKED) && !is_ctrl && over_limit;
  assign lock_now    = (state_reg == SEARCH) && !skip_reg && is_ctrl &&
                       (run_reg == RUN_W'(CTRL_RUN - 1));
  assign drop_now    = err_event && (err_reg == ERR_W'(ERR_LIMIT - 1));
  assign locked_next = ((state_reg == LOCKED) && !drop_now) || lock_now;
  assign offset_inc  = (offset_reg == 4'd9) ? 4'd0 : offset_reg + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= SEARCH;
      w1_reg       <= '0;
      w0_reg       <= '0;
      sym_reg      <= '0;
      skip_reg     <= 1'b0;
      offset_reg   <= '0;
      run_reg      <= '0;
      cyc_reg      <= '0;
      err_reg      <= '0;
      acc_reg      <= '0;
      vd_reg       <= '0;
      cd_reg       <= '0;
      vde_reg      <= 1'b0;
      locked_reg   <= 1'b0;
      disp_err_reg <= 1'b0;
    end else begin
      w1_reg       <= bus.tmds_in;
      w0_reg       <= w1_reg;
      sym_reg      <= sym_sel;
      skip_reg     <= 1'b0;
      disp_err_reg <= err_event;

      if (is_ctrl || err_event) begin
        acc_reg <= '0;
      end else begin
        acc_reg <= acc_sat;
      end

      // Output gating follows the lock state that the outputs are reported with.
      locked_reg <= locked_next;
      if (!locked_next) begin
        vde_reg <= 1'b0;
        cd_reg  <= 2'b00;
        vd_reg  <= 8'h00;
      end else if (is_ctrl) begin
        vde_reg <= 1'b0;
        cd_reg  <= ctrl_val;
        vd_reg  <= 8'h00;
      end else begin
        vde_reg <= 1'b1;
        vd_reg  <= vd_dec;
      end

      case (state_reg)
        SEARCH: begin
          if (lock_now) begin
            state_reg <= LOCKED;
            run_reg   <= '0;
            cyc_reg   <= '0;
            err_reg   <= '0;
          end else if (cyc_reg == CYC_W'(SEARCH_CYCLES - 1)) begin
            offset_reg <= offset_inc;
            run_reg    <= '0;
            cyc_reg    <= '0;
            skip_reg   <= 1'b1;
          end else begin
            cyc_reg <= cyc_reg + CYC_W'(1);
            // The symbol straddling an offset change was cut at the old offset.
            if (!skip_reg) begin
              run_reg <= is_ctrl ? run_reg + RUN_W'(1) : '0;
            end
          end
        end
        LOCKED: begin
          if (is_ctrl) begin
            err_reg <= '0;
          end else if (drop_now) begin
            state_reg  <= SEARCH;
            offset_reg <= offset_inc;
            err_reg    <= '0;
            run_reg    <= '0;
            cyc_reg    <= '0;
            skip_reg   <= 1'b1;
          end else if (err_event) begin
            err_reg <= err_reg + ERR_W'(1);
          end
        end
        default: state_reg <= SEARCH;
      endcase
    end
  end

  assign bus.VD           = vd_reg;
  assign bus.CD           = cd_reg;
  assign bus.VDE          = vde_reg;
  assign bus.locked       = locked_reg;
  assign bus.align_offset = offset_reg;
  assign bus.disp_err     = disp_err_reg;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: reset, aligned and shifted lock, offset wrap,
// disparity-driven loss of lock and an encoder-to-decoder round trip.
module tb_tmds_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tmds_decoder_if bus();

  tmds_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int enc_cnt = 0;
  int pc = 0;
  logic [9:0] prev_sym = '0;
  logic [9:0] tok_tab [4];
  bit         exp_ctrl [8];
  logic [1:0] exp_cd [8];
  logic [7:0] exp_vd [8];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Reference DVI encoder, independent of the decoder's structure.
  function automatic logic [9:0] tmds_encode(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1d, n1q, n0q;
    n1d = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8] == 1'b0) enc_cnt += n0q - n1q;
      else               enc_cnt += n1q - n0q;
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += -2 * int'(!qm[8]) + n1q - n0q;
    end
    return q;
  endfunction

  task automatic push(input logic [9:0] w);
    bus.tmds_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.tmds_in = 10'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Sends one symbol delayed by 7 bits in the serial stream, checking the output 3 words later.
  task automatic send_sym(input bit is_c, input logic [1:0] c, input logic [7:0] d, input bit verify);
    logic [9:0] s;
    int slot;
    if (is_c) begin
      s = tok_tab[c];
      enc_cnt = 0;
    end else begin
      s = tmds_encode(d);
    end
    exp_ctrl[pc % 8] = is_c;
    exp_cd[pc % 8]   = c;
    exp_vd[pc % 8]   = d;
    push({s[2:0], prev_sym[9:3]});
    prev_sym = s;
    if (verify && pc >= 3) begin
      slot = (pc - 3) % 8;
      if (exp_ctrl[slot]) begin
        check_val("rt_vde_ctrl", 32'(bus.VDE), 32'h0);
        check_val("rt_cd", 32'(bus.CD), 32'(exp_cd[slot]));
      end else begin
        check_val("rt_vde_data", 32'(bus.VDE), 32'h1);
        check_val("rt_vd", 32'(bus.VD), 32'(exp_vd[slot]));
      end
      check_val("rt_disp_err", 32'(bus.disp_err), 32'h0);
    end
    pc++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev_off;
    tok_tab[0] = 10'b1101010100;
    tok_tab[1] = 10'b0010101011;
    tok_tab[2] = 10'b0101010100;
    tok_tab[3] = 10'b1010101011;
    bus.tmds_in = '0;

    // Reset with random input
    do_reset(3);
    check_val("reset_vd", 32'(bus.VD), 32'h0);
    check_val("reset_cd", 32'(bus.CD), 32'h0);
    check_val("reset_vde", 32'(bus.VDE), 32'h0);
    check_val("reset_locked", 32'(bus.locked), 32'h0);
    check_val("reset_offset", 32'(bus.align_offset), 32'h0);
    check_val("reset_disp_err", 32'(bus.disp_err), 32'h0);

    // Aligned lock at offset 0, then one data word with 3-edge latency
    for (int i = 0; i < 8; i++) push(tok_tab[0]);
    enc_cnt = 0;
    push(tmds_encode(8'h5A));
    push(tok_tab[0]);
    push(tok_tab[0]);
    check_val("lock_locked", 32'(bus.locked), 32'h1);
    check_val("lock_offset", 32'(bus.align_offset), 32'h0);
    check_val("lock_vde_before", 32'(bus.VDE), 32'h0);
    check_val("lock_cd", 32'(bus.CD), 32'h0);
    push(tok_tab[0]);
    check_val("lat_vde", 32'(bus.VDE), 32'h1);
    check_val("lat_vd", 32'(bus.VD), 32'h5A);

    // Disparity: 0x3FF words, error every 4th, fourth error drops lock
    for (int j = 1; j <= 19; j++) begin
      push(10'h3FF);
      if (j >= 4) begin
        check_val($sformatf("disp_err_w%0d", j - 3), 32'(bus.disp_err), 32'(((j - 3) % 4) == 0));
      end
      if (j == 4) check_val("disp_vd", 32'(bus.VD), 32'h0);
      if (j == 18) check_val("disp_still_locked", 32'(bus.locked), 32'h1);
    end
    check_val("disp_unlocked", 32'(bus.locked), 32'h0);
    check_val("disp_offset_adv", 32'(bus.align_offset), 32'h1);

    // Mid-run reset returns the offset to 0, then the offset walks and wraps
    do_reset(1);
    check_val("rst2_offset", 32'(bus.align_offset), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      repeat (2047) push(10'h3FF);
      check_val($sformatf("wrap_hold_%0d", k), 32'(bus.align_offset), 32'((k - 1) % 10));
      push(10'h3FF);
      check_val($sformatf("wrap_step_%0d", k), 32'(bus.align_offset), 32'(k % 10));
    end
    check_val("wrap_unlocked", 32'(bus.locked), 32'h0);

    // Stream shifted by 7 bits: offset walks 0..7 then locks
    do_reset(1);
    enc_cnt  = 0;
    prev_sym = '0;
    pc       = 0;
    prev_off = 0;
    for (int line = 0; line < 400 && !bus.locked; line++) begin
      for (int s = 0; s < 64; s++) begin
        send_sym(s < 12, 2'b11, 8'($urandom), 1'b0);
        if (32'(bus.align_offset) != prev_off) begin
          check_val("shift_step", 32'(bus.align_offset), 32'(prev_off + 1));
          prev_off = int'(bus.align_offset);
        end
      end
    end
    check_val("shift_locked", 32'(bus.locked), 32'h1);
    check_val("shift_offset", 32'(bus.align_offset), 32'h7);
    for (int s = 0; s < 64; s++) begin
      send_sym(s < 12, 2'b11, 8'($urandom), 1'b1);
    end

    // Round trip: all control values, full byte sweep, then flush
    for (int i = 0; i < 8; i++) send_sym(1'b1, 2'(i % 4), 8'h00, 1'b1);
    for (int v = 0; v < 256; v++) send_sym(1'b0, 2'b00, 8'(v), 1'b1);
    for (int i = 0; i < 7; i++) send_sym(1'b1, 2'(i % 4), 8'h00, 1'b1);
    check_val("rt_locked_end", 32'(bus.locked), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
- Receive-side counterpart of the TMDS encoder for one HDMI/DVI colour channel.
- Accepts a raw 10-bit deserialized word per clock in arbitrary bit phase and finds the symbol boundary from runs of control tokens.
- Decodes each symbol back to 8-bit video data, 2-bit control data and a data-enable flag.
- Flags running-disparity violations and drops lock on sustained errors.

Parameters:
- CTRL_RUN, 8: consecutive identical-offset control tokens required to lock.
- SEARCH_CYCLES, 2048: cycles spent at one offset without locking before advancing the offset.
- ERR_LIMIT, 4: disparity errors since the last control token that force loss of lock.
- DISP_LIMIT, 16: magnitude bound on the running disparity accumulator.

Ports:
- clk  in  1  pixel clock, one 10-bit word per cycle.
- rst  in  1  synchronous reset, active-high.
- tmds_in  in  10  deserialized word; bit 0 is the earliest received bit.
- VD  out  8  decoded video data.
- CD  out  2  decoded control data.
- VDE  out  1  1 = VD valid, 0 = CD valid.
- locked  out  1  word alignment established.
- align_offset  out  4  current bit offset, 0..9.
- disp_err  out  1  one-cycle pulse on a disparity violation.

Behaviour:
- Reset (clk edge with rst=1): all outputs 0; internal state cleared (w1, w0, offset, counters, accumulator); FSM goes to SEARCH.
- Input pipeline: each edge w1<=tmds_in, w0<=w1. Window = {w1,w0} (20 bits). Symbol S = window[off+9:off].
- All outputs are registered. For offset 0, a word presented at tmds_in on edge N is reflected at the outputs after edge N+3. The same 3-edge latency applies at every offset, counted from the word holding the symbol's bit 0.
- Control tokens (S exact match):
  - 1101010100 -> CD=00
  - 0010101011 -> CD=01
  - 0101010100 -> CD=10
  - 1010101011 -> CD=11
- Any other S is a data symbol. Decoding:
  - d = S[9] ? ~S[7:0] : S[7:0]
  - VD[0] = d[0]
  - VD[i] = d[i]^d[i-1] if S[8]=1, else ~(d[i]^d[i-1]), for i = 1..7.
- Output rules:
  - locked=1, control S: VDE=0, CD=token value, VD=0.
  - locked=1, data S: VDE=1, VD=decoded value, CD holds its last value.
  - locked=0: VDE=0, CD=00, VD=00.
- Disparity accumulator (signed 6-bit, saturating at -32..+31):
  - Cleared to 0 on each control token.
  - On each data symbol, adds (popcount(S) - 5).
  - disp_err pulses only when locked=1 and the new |acc| > DISP_LIMIT; acc is then cleared to 0.
- FSM:
  - SEARCH:
    - run counter increments on each control token at the current offset; reset on any non-control S.
    - run reaching CTRL_RUN -> LOCKED: locked=1 from the next edge; err_cnt=0.
    - Cycle counter at SEARCH_CYCLES-1 without lock -> offset = offset+1 (9 wraps to 0); run and cycle counters cleared.
    - Offset changes take effect on the next edge; the symbol on that edge is ignored for the run count.
  - LOCKED:
    - Offset frozen.
    - err_cnt increments on each disp_err and clears on each control token.
    - err_cnt reaching ERR_LIMIT -> SEARCH with offset+1 (wrap), locked=0 on the next edge, counters cleared.
- Simultaneous events: a control token clears err_cnt before any increment; a control token can never raise disp_err.
- rst asserted mid-operation: full reset on that edge; offset returns to 0.

Test Plan:
- Reset: hold rst 3 cycles with random tmds_in -> all outputs 0, align_offset=0, FSM in SEARCH.
- Aligned lock: 8 words of 1101010100 at offset 0 -> locked=1; align_offset=0; VDE=0, CD=00. Then the encoder output for VD=0x5A -> VDE=1, VD=0x5A, exactly 3 edges after input.
- Misaligned lock: encoder stream (12 control tokens CD=11 per 64-symbol line, random data) shifted by 7 bits -> offset steps 0..7, then locked=1 with align_offset=7. Decoded VD equals the encoder input byte-for-byte.
- Offset wrap: constant 0x3FF input -> no lock; align_offset increments every 2048 cycles, 9 wraps to 0.
- Disparity: while locked, inject four 0x3FF words (+5 each) -> disp_err pulses on the 4th word (acc=20). Repeat 4 times without a control token -> locked drops and align_offset advances by 1.
- Round trip: encoder(VD 0..255 sweep, VDE, CD all four values) -> decoder. Output equals input delayed by the fixed latency; disp_err never asserts.
